// File: rtl/coin_dispense.sv
// coin_dispense: change-coin hopper driver for the sale controller.
// Pulses the eject solenoid once per coin and tracks hopper inventory.
module coin_dispense #(
    parameter int PULSE_W  = 2,
    parameter int GAP_W    = 2,
    parameter int HOP_W    = 6,
    parameter int HOP_INIT = 20,
    parameter int REFILL_N = 10
) (
    input  logic             clk,
    input  logic             rset,
    input  logic             chg_vld,
    input  logic [1:0]       chg_cnt,
    output logic             chg_rdy,
    output logic             coin_out,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [1:0]       disp_cnt,
    input  logic             refill,
    output logic [HOP_W-1:0] hop_lvl,
    output logic             hop_empty
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Timer counts down from (width - 1); sized for the longer phase.
    localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int HW1  = HOP_W + 1;

    localparam logic [TW-1:0]  T_PULSE  = TW'(PULSE_W - 1);
    localparam logic [TW-1:0]  T_GAP    = TW'(GAP_W - 1);
    localparam logic [HW1-1:0] HOP_MAX  = {1'b0, {HOP_W{1'b1}}};
    localparam logic [HW1-1:0] HOP_ADD  = HW1'(REFILL_N);
    localparam logic [HOP_W-1:0] HOP_RST = HOP_W'(HOP_INIT);

    logic [1:0]       state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [1:0]       disp_q, disp_d;
    logic             short_q, short_d;
    logic             coin_q;
    logic [HOP_W-1:0] hop_q, hop_d;
    logic [HW1-1:0]   hop_sum;
    logic             enter_pulse;
    logic             tmr_zero;
    logic             hop_avail;

    assign tmr_zero  = (tmr_q == '0);
    assign hop_avail = (hop_q != '0);

    // Sequencing: request acceptance, pulse/gap timing and bookkeeping.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        tmr_d       = tmr_q;
        disp_d      = disp_q;
        short_d     = short_q;
        enter_pulse = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (chg_vld) begin
                    rem_d   = chg_cnt;
                    disp_d  = 2'd0;
                    short_d = 1'b0;
                    if ((chg_cnt != 2'd0) && hop_avail) begin
                        state_d     = S_PULSE;
                        enter_pulse = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        short_d = (chg_cnt != 2'd0);
                    end
                end
            end
            S_PULSE: begin
                if (tmr_zero) begin
                    if ((rem_q != 2'd0) && hop_avail) begin
                        state_d = S_GAP;
                        tmr_d   = T_GAP;
                    end else begin
                        state_d = S_DONE;
                        short_d = (rem_q != 2'd0);
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_zero) begin
                    state_d     = S_PULSE;
                    enter_pulse = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Every PULSE entry commits exactly one coin.
        if (enter_pulse) begin
            rem_d  = rem_d - 2'd1;
            disp_d = disp_d + 2'd1;
            tmr_d  = T_PULSE;
        end
    end

    // Inventory: refill and coin ejection combine, saturating at full scale.
    // PULSE is only entered with a non-empty hopper, so no underflow.
    always_comb begin
        hop_sum = {1'b0, hop_q};
        if (refill) begin
            hop_sum = hop_sum + HOP_ADD;
        end
        if (enter_pulse) begin
            hop_sum = hop_sum - 1'b1;
        end
        if (hop_sum > HOP_MAX) begin
            hop_d = HOP_MAX[HOP_W-1:0];
        end else begin
            hop_d = hop_sum[HOP_W-1:0];
        end
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_q <= S_IDLE;
            rem_q   <= 2'd0;
            tmr_q   <= '0;
            disp_q  <= 2'd0;
            short_q <= 1'b0;
            hop_q   <= HOP_RST;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tmr_q   <= tmr_d;
            disp_q  <= disp_d;
            short_q <= short_d;
            hop_q   <= hop_d;
        end
    end

    // Solenoid drive straight from a flop so it cannot glitch.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            coin_q <= 1'b0;
        end else begin
            coin_q <= (state_d == S_PULSE);
        end
    end

    assign chg_rdy   = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign coin_out  = coin_q;
    assign short     = short_q;
    assign disp_cnt  = disp_q;
    assign hop_lvl   = hop_q;
    assign hop_empty = (hop_q == '0);

endmodule
